product_bcd_converter: RTL

Sequential binary-to-BCD converter directly downstream of the 8×8 signed multiplier. It captures the 16-bit product formed by concatenating register A (high byte) and register B (low byte) on a start strobe. It converts the magnitude to five BCD digits with one double-dabble shift per clock, then presents digits plus a sign flag for the hex display path. The multiplier's control FSM and hex driver are unchanged; this block only consumes the product bus.

---
 rtl/product_bcd_converter.sv | 78 +++++++
 1 files changed

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: double-dabble binary-to-BCD of the multiplier product, one shift per clock.
// Define BCD_SIGNED_INPUT_EN to treat Product as two's complement (magnitude converted, sign on Neg).
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      Product,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Neg,
    output logic [4*DIGITS-1:0]   Bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0]    bin, mag;
    logic [4*DIGITS-1:0] bcd_w, bcd_adj;
    logic [CW-1:0]       cnt;
    logic                sign_p, sign_in;
`ifdef BCD_SIGNED_INPUT_EN
    // Truncated negate is exact here: the most negative input yields its unsigned magnitude.
    assign mag     = Product[WIDTH-1] ? -Product : Product;
    assign sign_in = Product[WIDTH-1];
`else
    assign mag     = Product;
    assign sign_in = 1'b0;
`endif
    assign Busy = state != IDLE;
    always_comb begin
        bcd_adj = bcd_w;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd_w[4*i +: 4] >= 4'd5 ? bcd_w[4*i +: 4] + 4'd3 : bcd_w[4*i +: 4];
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Start ? SHIFT : IDLE;
            SHIFT:   state_nxt = cnt == CW'(1) ? DONE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk)
        state <= Reset ? IDLE : state_nxt;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin    <= '0;
            bcd_w  <= '0;
            cnt    <= '0;
            sign_p <= 1'b0;
            Bcd    <= '0;
            Neg    <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    bin    <= mag;
                    sign_p <= sign_in;
                    bcd_w  <= '0;
                    cnt    <= CW'(WIDTH);
                end
                SHIFT: begin
                    {bcd_w, bin} <= {bcd_adj[4*DIGITS-2:0], bin, 1'b0};
                    cnt          <= cnt - 1'b1;
                end
                DONE: begin
                    Bcd  <= bcd_w;
                    Neg  <= sign_p;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
